// File: rtl/uart_cmd_link.sv
// Command serializer: sends {rw,addr,data} as two 8N1 frames (high byte first), then for reads
// receives one 8N1 response byte. Optional read timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_link #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] cmd,
    input  logic                           uart_valid,
    output logic                           uart_ready,
    output logic                           tx,
    input  logic                           rx,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           read_valid,
    output logic                           frame_err,
    output logic                           rd_timeout
);

    localparam int CMD_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
`ifdef UART_CMD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_TX_HI, S_TX_LO, S_RX_WAIT, S_RX_BYTE} state_t;

    state_t                r_state;
    logic [CMD_W-1:0]      r_cmd;
    logic [CW-1:0]         r_clk_cnt;
    logic [3:0]            r_bit_idx;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_hunt;
    logic [1:0]            r_rx_sync;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_tx;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_frame_err;
    logic                  r_rd_timeout;

    logic                  w_rx;
    logic                  w_rw;
    logic [DATA_WIDTH-1:0] w_tx_byte;

    assign w_rx      = r_rx_sync[1];
    assign w_rw      = r_cmd[CMD_W-1];
    assign w_tx_byte = (r_state == S_TX_HI) ? r_cmd[CMD_W-1 -: DATA_WIDTH] : r_cmd[DATA_WIDTH-1:0];

    // Frame bit index: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic f_frame_bit(input logic [DATA_WIDTH-1:0] b, input logic [3:0] idx);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx >= 4'd9)
            return 1'b1;
        else
            return b[3'(idx - 4'd1)];
    endfunction

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_to_cnt     <= '0;
            r_hunt       <= 1'b0;
            r_rx_sync    <= 2'b11;
            r_rx_shift   <= '0;
            r_tx         <= 1'b1;
            r_ready      <= 1'b1;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rd_timeout <= 1'b0;
        end else begin
            r_rx_sync    <= {r_rx_sync[0], rx};
            r_read_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rd_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (uart_valid && r_ready) begin
                        r_cmd     <= cmd;
                        r_state   <= S_TX_HI;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                    end
                end
                S_TX_HI, S_TX_LO: begin
                    if (r_clk_cnt != BIT_LAST) begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end else begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx != 4'd9) begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= f_frame_bit(w_tx_byte, r_bit_idx + 4'd1);
                        end else begin
                            r_bit_idx <= '0;
                            // Low frame starts right after the high stop bit, no idle gap.
                            if (r_state == S_TX_HI) begin
                                r_state <= S_TX_LO;
                                r_tx    <= 1'b0;
                            end else if (w_rw) begin
                                r_state <= S_IDLE;
                                r_ready <= 1'b1;
                            end else begin
                                r_state  <= S_RX_WAIT;
                                r_hunt   <= 1'b0;
                                r_to_cnt <= '0;
                            end
                        end
                    end
                end
                S_RX_WAIT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (r_hunt && r_clk_cnt == HALF_LAST && !w_rx) begin
                        r_state   <= S_RX_BYTE;
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_hunt    <= 1'b0;
                    end else if (TIMEOUT_EN && r_to_cnt == TO_LAST) begin
                        r_state      <= S_IDLE;
                        r_ready      <= 1'b1;
                        r_read_data  <= '1;
                        r_read_valid <= 1'b1;
                        r_rd_timeout <= 1'b1;
                        r_hunt       <= 1'b0;
                    end else if (r_hunt) begin
                        // Line went back high before mid-start: false start, keep waiting.
                        if (r_clk_cnt == HALF_LAST)
                            r_hunt <= 1'b0;
                        else
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                    end else if (!w_rx) begin
                        r_hunt    <= 1'b1;
                        r_clk_cnt <= '0;
                    end
                end
                S_RX_BYTE: begin
                    if (r_clk_cnt != BIT_LAST) begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end else begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx != 4'(DATA_WIDTH)) begin
                            r_rx_shift <= {w_rx, r_rx_shift[DATA_WIDTH-1:1]};
                            r_bit_idx  <= r_bit_idx + 1'b1;
                        end else begin
                            if (w_rx) begin
                                r_read_data  <= r_rx_shift;
                                r_read_valid <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uart_ready = r_ready;
    assign tx         = r_tx;
    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign frame_err  = r_frame_err;
    assign rd_timeout = r_rd_timeout;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link: write/read frames, false start, framing error,
// backpressure, mid-frame reset, and read timeout (when UART_CMD_TIMEOUT_EN is defined).
module tb_uart_cmd_link;

    localparam int CPB = 16;
    localparam int TO  = 100;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [15:0] cmd;
    logic        uart_valid;
    logic        uart_ready;
    logic        tx;
    logic        rx;
    logic [7:0]  read_data;
    logic        read_valid;
    logic        frame_err;
    logic        rd_timeout;

    int n_chk = 0;
    int n_err = 0;
    int n_rv  = 0;
    int n_fe  = 0;
    int n_to  = 0;
    int n_acc = 0;
    logic [7:0] rv_data  = 8'h00;
    logic       rv_ready = 1'b0;

    uart_cmd_link #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cmd(cmd), .uart_valid(uart_valid),
        .uart_ready(uart_ready), .tx(tx), .rx(rx), .read_data(read_data),
        .read_valid(read_valid), .frame_err(frame_err), .rd_timeout(rd_timeout)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (read_valid) begin
            n_rv     <= n_rv + 1;
            rv_data  <= read_data;
            rv_ready <= uart_ready;
        end
        if (frame_err)  n_fe <= n_fe + 1;
        if (rd_timeout) n_to <= n_to + 1;
    end

    always @(posedge PCLK)
        if (!PRESET && uart_valid && uart_ready) n_acc <= n_acc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge just after the accepting edge.
    task automatic accept(input logic [15:0] c, input logic hold);
        chk("ready_idle", uart_ready, 1);
        cmd = c;
        uart_valid = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        if (!hold) uart_valid = 1'b0;
    endtask

    // Decodes both frames at mid-bit and checks busy/ready boundaries (ready low 320 cycles).
    task automatic tx_check(input logic [15:0] c, input logic exp_rdy_end);
        int cur;
        logic [19:0] bits;
        cur = 0;
        chk("tx_start_now", tx, 0);
        chk("ready_busy", uart_ready, 0);
        for (int j = 0; j < 20; j++) begin
            while (cur < j*CPB + CPB/2) begin @(negedge PCLK); cur++; end
            bits[j] = tx;
        end
        chk("hi_start", bits[0], 0);
        chk("hi_byte", bits[8:1], c[15:8]);
        chk("hi_stop", bits[9], 1);
        chk("lo_start", bits[10], 0);
        chk("lo_byte", bits[18:11], c[7:0]);
        chk("lo_stop", bits[19], 1);
        while (cur < 20*CPB - 1) begin @(negedge PCLK); cur++; end
        chk("ready_last_busy", uart_ready, 0);
        @(negedge PCLK);
        chk("ready_end", uart_ready, exp_rdy_end);
        chk("tx_idle_end", tx, 1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge PCLK);
        end
        rx = stop;
        repeat (CPB) @(negedge PCLK);
        rx = 1'b1;
        repeat (12) @(negedge PCLK);
    endtask

    initial begin
        int s_rv, s_fe, s_acc, s_to;
        PRESET = 1'b1; cmd = '0; uart_valid = 1'b0; rx = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_tx", tx, 1);
        chk("rst_ready", uart_ready, 1);
        chk("rst_rdata", read_data, 0);
        chk("rst_rvalid", read_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_tout", rd_timeout, 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Write A53C
        s_rv = n_rv;
        accept(16'hA53C, 1'b0);
        tx_check(16'hA53C, 1'b1);
        repeat (4) @(negedge PCLK);
        chk("wr_no_rvalid", n_rv - s_rv, 0);

        // Read 1200, response 5A
        s_rv = n_rv; s_fe = n_fe;
        accept(16'h1200, 1'b0);
        tx_check(16'h1200, 1'b0);
        rx_frame(8'h5A, 1'b1);
        chk("rd_rvalid_cnt", n_rv - s_rv, 1);
        chk("rd_rdata_at_pulse", rv_data, 8'h5A);
        chk("rd_ready_at_pulse", rv_ready, 1);
        chk("rd_no_ferr", n_fe - s_fe, 0);
        chk("rd_rdata_hold", read_data, 8'h5A);

        // False start glitch then C3
        s_rv = n_rv;
        accept(16'h2400, 1'b0);
        tx_check(16'h2400, 1'b0);
        rx = 1'b0;
        repeat (3) @(negedge PCLK);
        rx = 1'b1;
        repeat (20) @(negedge PCLK);
        chk("glitch_no_rvalid", n_rv - s_rv, 0);
        chk("glitch_still_busy", uart_ready, 0);
        rx_frame(8'hC3, 1'b1);
        chk("glitch_rvalid_cnt", n_rv - s_rv, 1);
        chk("glitch_rdata", read_data, 8'hC3);

        // Framing error on 77
        s_rv = n_rv; s_fe = n_fe;
        accept(16'h0500, 1'b0);
        tx_check(16'h0500, 1'b0);
        rx_frame(8'h77, 1'b0);
        chk("ferr_cnt", n_fe - s_fe, 1);
        chk("ferr_no_rvalid", n_rv - s_rv, 0);
        chk("ferr_rdata_kept", read_data, 8'hC3);
        chk("ferr_idle", uart_ready, 1);

        // Backpressure: 8001 held valid through the A53C busy period
        s_acc = n_acc;
        accept(16'hA53C, 1'b1);
        cmd = 16'h8001;
        tx_check(16'hA53C, 1'b1);
        @(negedge PCLK);
        uart_valid = 1'b0;
        tx_check(16'h8001, 1'b1);
        repeat (20) @(negedge PCLK);
        chk("bp_accept_cnt", n_acc - s_acc, 2);

        // Reset mid-TX_HI (data bit 1 of 0x80 is 0)
        accept(16'h8001, 1'b0);
        repeat (40) @(negedge PCLK);
        chk("mid_tx_low", tx, 0);
        chk("mid_busy", uart_ready, 0);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_ready", uart_ready, 1);
        chk("rst_mid_rdata", read_data, 0);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("post_rst_tx", tx, 1);

`ifdef UART_CMD_TIMEOUT_EN
        accept(16'h3300, 1'b0);
        tx_check(16'h3300, 1'b0);
        repeat (TO - 1) @(negedge PCLK);
        chk("to_early_tout", rd_timeout, 0);
        chk("to_early_rvalid", read_valid, 0);
        @(negedge PCLK);
        chk("to_tout", rd_timeout, 1);
        chk("to_rvalid", read_valid, 1);
        chk("to_rdata", read_data, 8'hFF);
        chk("to_ready", uart_ready, 1);
`else
        s_to = n_to;
        accept(16'h3300, 1'b0);
        tx_check(16'h3300, 1'b0);
        repeat (2*TO) @(negedge PCLK);
        chk("noto_tout_cnt", n_to - s_to, 0);
        chk("noto_still_busy", uart_ready, 0);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("noto_rst_ready", uart_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
